// File: rtl/imem_loader.sv
// Instruction memory loader: receives a framed byte image from a host link,
// assembles little-endian 32-bit words, writes them into instruction RAM and
// holds the CPU in reset until the whole image has passed its checksum.
module imem_loader #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [7:0]  n_words;
  logic [7:0]  word_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic [23:0] word_buf;

  // Status outputs decoded straight from the state register.
  assign in_ready  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign cpu_reset = (state != S_DONE);

  // Frame parser, word assembly and registered RAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      n_words  <= 8'd0;
      word_idx <= 8'd0;
      byte_idx <= 2'd0;
      csum     <= 8'd0;
      word_buf <= 24'd0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= 32'd0;
    end else begin
      we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_HDR;
        end
        S_HDR: begin
          if (in_valid) begin
            n_words  <= in_data;
            word_idx <= 8'd0;
            byte_idx <= 2'd0;
            csum     <= 8'd0;
            if (in_data == 8'd0)         state <= S_CSUM;
            else if (in_data > DEPTH_B)  state <= S_ERR;
            else                         state <= S_DATA;
          end
        end
        S_DATA: begin
          if (in_valid) begin
            csum <= csum ^ in_data;
            if (byte_idx == 2'd3) begin
              // Fourth byte completes the word; write it on the next cycle.
              we       <= 1'b1;
              waddr    <= ADDR_W'(word_idx);
              wdata    <= {in_data, word_buf};
              byte_idx <= 2'd0;
              word_idx <= word_idx + 8'd1;
              if (word_idx == n_words - 8'd1) state <= S_CSUM;
            end else begin
              word_buf[{byte_idx, 3'b000} +: 8] <= in_data;
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        S_CSUM: begin
          if (in_valid) state <= (in_data == csum) ? S_DONE : S_ERR;
        end
        S_DONE: begin
          if (start) state <= S_HDR;
        end
        S_ERR: begin
          if (start) state <= S_HDR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frame table, hand-written corner
// sequences, and random frames checked against a frame-level reference model.
module tb_imem_loader;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t  wq[$];
  logic prev_we = 1'b0;

  typedef struct {
    int              len;
    int              gap;
    logic [0:9][7:0] b;
    int              n_wr;
    logic [31:0]     w0;
    logic [31:0]     w1;
    logic            exp_done;
  } vec_t;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Capture every RAM write and make sure write strobes never touch.
  always @(negedge clk) begin
    if (we) begin
      check("we_not_back_to_back", 32'(prev_we), 32'd0);
      wq.push_back('{addr: waddr, data: wdata});
    end
    prev_we = we;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    logic [7:0] frame[$];
    logic [7:0] n;
    logic [7:0] x;
    logic [7:0] cs;
    logic [31:0] w;
    int exp_wr;
    logic exp_done;

    vecs[0] = '{len: 6,  gap: 0, b: {8'h01, 8'hB3, 8'h03, 8'h53, 8'h00, 8'hE3, 32'h0},
                n_wr: 1, w0: 32'h005303B3, w1: 32'h0, exp_done: 1'b1};
    vecs[1] = '{len: 10, gap: 3, b: {8'h02, 8'h44, 8'h33, 8'h22, 8'h11,
                                     8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h44},
                n_wr: 2, w0: 32'h11223344, w1: 32'hA5A5A5A5, exp_done: 1'b1};
    vecs[2] = '{len: 2,  gap: 0, b: {8'h00, 8'h00, 64'h0},
                n_wr: 0, w0: 32'h0, w1: 32'h0, exp_done: 1'b1};
    vecs[3] = '{len: 2,  gap: 0, b: {8'h00, 8'h01, 64'h0},
                n_wr: 0, w0: 32'h0, w1: 32'h0, exp_done: 1'b0};
    vecs[4] = '{len: 6,  gap: 1, b: {8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 32'h0},
                n_wr: 1, w0: 32'hDEADBEEF, w1: 32'h0, exp_done: 1'b0};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_we",        32'(we),        32'd0);
    check("rst_waddr",     32'(waddr),     32'd0);
    check("rst_wdata",     wdata,          32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed frame table.
    for (int v = 0; v < 5; v++) begin
      wq.delete();
      pulse_start();
      check("hdr_in_ready",  32'(in_ready),  32'd1);
      check("hdr_done",      32'(done),      32'd0);
      check("hdr_error",     32'(error),     32'd0);
      check("hdr_cpu_reset", 32'(cpu_reset), 32'd1);
      for (int j = 0; j < vecs[v].len; j++) begin
        send_byte(vecs[v].b[j], vecs[v].gap);
        if (j >= 1 && (j % 4) == 0 && j <= 4 * int'(vecs[v].b[0])) begin
          check("we_latency", 32'(we),    32'd1);
          check("we_addr",    32'(waddr), 32'(j / 4 - 1));
        end
      end
      check("vec_nwr",       32'(wq.size()), 32'(vecs[v].n_wr));
      if (wq.size() > 0) begin
        check("vec_w0_addr", 32'(wq[0].addr), 32'd0);
        check("vec_w0_data", wq[0].data,      vecs[v].w0);
      end
      if (wq.size() > 1) begin
        check("vec_w1_addr", 32'(wq[1].addr), 32'd1);
        check("vec_w1_data", wq[1].data,      vecs[v].w1);
      end
      check("vec_done",      32'(done),      32'(vecs[v].exp_done));
      check("vec_error",     32'(error),     32'(!vecs[v].exp_done));
      check("vec_cpu_reset", 32'(cpu_reset), 32'(!vecs[v].exp_done));
      check("vec_in_ready",  32'(in_ready),  32'd0);
    end

    // Oversized header is rejected and no further bytes are taken.
    wq.delete();
    pulse_start();
    send_byte(8'h21, 0);
    check("big_error",    32'(error),    32'd1);
    check("big_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("big_no_accept", 32'(in_ready), 32'd0);
      check("big_hold_err",  32'(error),    32'd1);
    end
    in_valid = 1'b0;
    check("big_no_we", 32'(wq.size()), 32'd0);

    // Reset in the middle of a word discards it.
    wq.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_in_ready",  32'(in_ready),  32'd0);
    check("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid_done",      32'(done),      32'd0);
    check("mid_error",     32'(error),     32'd0);
    repeat (6) @(negedge clk);
    check("mid_no_we",     32'(wq.size()), 32'd0);
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_byte(8'h08, 0);
    check("mid_reload_nwr",  32'(wq.size()), 32'd1);
    if (wq.size() > 0) begin
      check("mid_reload_addr", 32'(wq[0].addr), 32'd0);
      check("mid_reload_data", wq[0].data,      32'h12345678);
    end
    check("mid_reload_done", 32'(done), 32'd1);

    // Random frames against a frame-level reference model.
    for (int it = 0; it < 30; it++) begin
      frame.delete();
      n = 8'($urandom_range(0, DEPTH + 2));
      frame.push_back(n);
      x = 8'h00;
      for (int i = 0; i < 4 * int'(n); i++) begin
        frame.push_back(8'($urandom_range(0, 255)));
        x = x ^ frame[frame.size() - 1];
      end
      cs = x;
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      frame.push_back(cs);

      exp_wr   = (int'(n) <= DEPTH) ? int'(n) : 0;
      exp_done = (int'(n) <= DEPTH) && (cs == x);

      wq.delete();
      pulse_start();
      for (int j = 0; j < frame.size(); j++) begin
        send_byte(frame[j], $urandom_range(0, 2));
        if (j == 0 && int'(n) > DEPTH) break;
      end
      check("rnd_nwr", 32'(wq.size()), 32'(exp_wr));
      for (int i = 0; i < wq.size() && i < exp_wr; i++) begin
        w = {frame[4*i+4], frame[4*i+3], frame[4*i+2], frame[4*i+1]};
        check("rnd_addr", 32'(wq[i].addr), 32'(i));
        check("rnd_data", wq[i].data,      w);
      end
      check("rnd_done",      32'(done),      32'(exp_done));
      check("rnd_error",     32'(error),     32'(!exp_done));
      check("rnd_cpu_reset", 32'(cpu_reset), 32'(!exp_done));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
